// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment codes {g,f,e,d,c,b,a}
// (active-low), blanking values and the digit-slot type.
package seg7_pkg;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  function automatic logic [3:0] an_code(input digit_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with double-buffered value/dp.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;
  digit_t        idx;
  logic [15:0]   shadow_val, disp_val;
  logic [3:0]    shadow_dp, disp_dp;
  logic          tick, commit, blank;
  logic [3:0]    nibble;
  logic [6:0]    dec;

  assign tick       = en && (cnt == CW'(PRESCALE - 1));
  assign commit     = tick && (idx == DIG3);
  assign frame_tick = commit;
  assign nibble     = disp_val[{idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec)
  );

`ifdef SEG7_LZB_EN
  always_comb begin
    blank = 1'b0;
    case (idx)
      DIG3:    blank = (disp_val[15:12] == '0);
      DIG2:    blank = (disp_val[15:8]  == '0);
      DIG1:    blank = (disp_val[15:4]  == '0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= DIG0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= digit_t'(idx + 2'd1);
      if (commit) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pending  <= 1'b0;
      end
      // A coincident load still wins pending; the commit above takes the old shadow.
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
        pending    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else if (!en) begin
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else begin
      an   <= an_code(idx);
      seg  <= blank ? SEG_OFF : dec;
      dp_n <= ~disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a time-based reference model.
module tb_seg7_scan_driver;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;

  int unsigned checks = 0;
  int unsigned errors = 0;

  seg7_scan_driver #(.PRESCALE(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .pending    (pending),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Model: position in the scan is just the number of enabled cycles since reset.
  int unsigned m_ecnt;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;
  logic [6:0]  hex_tab [16];

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_digit();
    return (m_ecnt / P) % 4;
  endfunction

  function automatic logic m_commit(input logic e);
    return e && ((m_ecnt % (4 * P)) == (4 * P - 1));
  endfunction

  function automatic logic [6:0] m_seg(input int unsigned k);
    logic [3:0] nib;
    nib = 4'((m_disp >> (4 * k)) & 16'hF);
`ifdef SEG7_LZB_EN
    if (k > 0 && (m_disp >> (4 * k)) == 0) return 7'h7F;
`endif
    return hex_tab[nib];
  endfunction

  task automatic model_reset();
    m_ecnt = 0; m_shadow = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 1'b0;
  endtask

  // Called just after a falling edge: drive, check the combinational pulse,
  // take the rising edge, then check registered outputs.
  task automatic cycle(input logic e, input logic ld, input logic [15:0] v, input logic [3:0] d);
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_dpn, x_commit;
    int unsigned k;
    en = e; load = ld; value = v; dp = d;
    x_commit = m_commit(e);
    #1;
    check("frame_tick", 32'(frame_tick), 32'(x_commit));
    k = m_digit();
    if (e) begin
      x_an  = ~(4'b0001 << k);
      x_seg = m_seg(k);
      x_dpn = ~m_ddp[k];
    end else begin
      x_an = 4'hF; x_seg = 7'h7F; x_dpn = 1'b1;
    end
    if (x_commit) begin
      m_disp = m_shadow; m_ddp = m_sdp; m_pend = 1'b0;
    end
    if (ld) begin
      m_shadow = v; m_sdp = d; m_pend = 1'b1;
    end
    if (e) m_ecnt++;
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(x_an));
    check("seg", 32'(seg), 32'(x_seg));
    check("dp_n", 32'(dp_n), 32'(x_dpn));
    check("pending", 32'(pending), 32'(m_pend));
    @(negedge clk);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp_n", 32'(dp_n), 32'h1);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp = '0;
    @(negedge clk);
    do_reset();

    run(40);

    run(5);
    cycle(1'b1, 1'b1, 16'h12AF, 4'b0001);
    run(40);

    cycle(1'b1, 1'b1, 16'h1111, 4'b0000);
    run(2);
    cycle(1'b1, 1'b1, 16'h2222, 4'b1000);
    run(40);

    run(2);
    for (int unsigned i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0, 4'h0);
    run(20);

    // Land a load exactly on the commit cycle.
    cycle(1'b1, 1'b1, 16'h3C4D, 4'b0110);
    for (int unsigned i = 0; i < 64 && !m_commit(1'b1); i++) run(1);
    cycle(1'b1, 1'b1, 16'h5A5A, 4'b1001);
    check("pend_after_coincident", 32'(pending), 32'h1);
    run(40);

    for (int unsigned i = 0; i < 2000; i++) begin
      logic e, ld;
      e  = ($urandom_range(0, 15) != 0);
      ld = m_commit(e) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 11) == 0);
      if (i == 1000) begin
        @(negedge clk);
        do_reset();
      end
      cycle(e, ld, 16'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter: PRESCALE, 100000, clk cycles per digit slot; legal range 2..2^20.
REQ-002 Port: clk  input  1  clock; all state on rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: en  input  1  scan enable; 0 freezes the scan and blanks the display.
REQ-005 Port: value  input  16  four hex digits; digit k = value[4k+3:4k].
REQ-006 Port: dp  input  4  decimal point request per digit, active-high.
REQ-007 Port: load  input  1  single-cycle strobe; captures value and dp into the shadow register.
REQ-008 Port: pending  output  1  shadow holds data not yet committed to the display.
REQ-009 Port: an  output  4  digit anodes, active-low one-hot.
REQ-010 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port: dp_n  output  1  decimal point, active-low.
REQ-012 Port: frame_tick  output  1  one-cycle pulse at frame commit.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 while en=1, wrap to 0, and hold its value while en=0; tick = (en && count==PRESCALE-1).
REQ-014 Digit index idx (2 bits) SHALL increment on tick and wrap 3->0.
REQ-015 Frame commit SHALL occur on tick with idx==3: display register <= shadow, pending <= 0, frame_tick=1 for that cycle.
REQ-016 load SHALL write the shadow and set pending=1; when load and a commit coincide, the old shadow SHALL commit and the new value SHALL remain in the shadow with pending=1.
REQ-017 load while pending=1 SHALL overwrite the shadow (last write wins).
REQ-018 an, seg and dp_n SHALL be registered: one clk cycle after idx or the display register changes.
REQ-019 an SHALL follow idx: 0->1110, 1->1101, 2->1011, 3->0111; en=0 SHALL force an=1111, seg=1111111, dp_n=1.
REQ-020 seg SHALL be the standard hex decode of the selected nibble; 0->1000000, 1->1111001, 8->0000000, F->0001110.
REQ-021 dp_n SHALL be the inverse of the committed dp bit for the selected digit.

Reset
REQ-022 Reset SHALL clear the prescaler, idx, display register, shadow, pending and frame_tick, and SHALL set an=1111, seg=1111111, dp_n=1.
REQ-023 Reset asserted mid-frame SHALL discard the shadow and pending data; scanning restarts at idx=0 after release.

Configuration
REQ-024 Macro SEG7_LZB_EN defined: digit k (k=3..1) SHALL show seg=1111111 (an still driven) when nibbles k..3 of the display register are all zero; digit 0 SHALL never blank; dp_n is unaffected.
REQ-025 Macro SEG7_LZB_EN undefined: all four digits SHALL always decode their nibble.

Structure
REQ-026 Shared package seg7_pkg SHALL hold the segment code constants (0-F), AN_OFF=4'b1111 and SEG_OFF=7'b1111111.
REQ-027 A combinational sub-module seg7_hex_decode (4-bit in, 7-bit active-low out) SHALL implement the REQ-020 decode.

Verification (PRESCALE=4)
REQ-028 Reset, en=1, no load -> an cycles 1110,1101,1011,0111 with 4 clk per digit; seg=1000000 throughout (without SEG7_LZB_EN).
REQ-029 load value=16'h12AF mid-frame -> pending=1 until the commit; after frame_tick, digit 0 seg=0001110 and digit 3 seg=1111001; pending=0.
REQ-030 load 16'h1111, then load 16'h2222 before the commit -> only 2222 is ever displayed.
REQ-031 load asserted in the commit cycle -> the old shadow is displayed, pending stays 1, and the new value appears one frame later.
REQ-032 en=0 for 10 cycles mid-digit -> an=1111 and the prescaler holds; on en=1 the scan resumes at the same digit and count.
REQ-033 SEG7_LZB_EN defined, value=16'h0040 -> digits 3 and 2 show seg=1111111, digit 1 shows 4 (0011001), digit 0 shows 0 (1000000).
